game_reset_sequencer: RTL and testbench

GAME_RESET_SEQUENCER -- requirements
Module: game_reset_sequencer

---
 rtl/game_reset_sequencer.sv | 105 ++++++++++
 tb/tb_game_reset_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/game_reset_sequencer.sv
// game_reset_sequencer: captures a game-ROM download, validates the image and
// sequences the game core's reset.
// Ports:
//   clk_sys                   sole clock, rising edge
//   reset_n                   asynchronous active-low reset, release synchronized
//   ioctl_downl/index/wr/addr/dout  download interface from the framework
//   status_rst, button_rst    level reset requests (OSD, board button)
//   core_reset                active-high reset to the game core
//   dn_wr, dn_addr, dn_data   registered ROM write port to the game core
//   rom_ok, load_err          image valid / last download short or all-zero
//   led_n                     low while a download is active
module game_reset_sequencer #(
  parameter logic [7:0] ROM_INDEX   = 8'h00,
  parameter int         ROM_SIZE    = 16384,
  parameter int         HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        status_rst,
  input  logic        button_rst,
  output logic        core_reset,
  output logic        dn_wr,
  output logic [13:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        rom_ok,
  output logic        load_err,
  output logic        led_n
);
  typedef enum logic [2:0] {NOROM, LOAD, CHECK, HOLD, RUN} state_t;
  state_t      state, state_nx;
  logic [1:0]  rst_sync;
  logic        dl_q;
  logic [15:0] hold_cnt;
  logic [14:0] byte_cnt;
  logic        nz;
  logic        rom_dl, dl_rise, dl_fall, cause, acc, valid, load_entry;
  assign rom_dl     = ioctl_downl && (ioctl_index == ROM_INDEX);
  assign dl_rise    = rom_dl && !dl_q;
  assign dl_fall    = !rom_dl && dl_q;
  assign cause      = status_rst || button_rst;
  assign acc        = ioctl_wr && rom_dl && (ioctl_addr < 25'(ROM_SIZE));
  assign valid      = (byte_cnt == 15'(ROM_SIZE)) && nz;
  assign load_entry = (state_nx == LOAD) && (state != LOAD);
  // A new download always wins over a reset cause; NOROM waits for the
  // synchronized reset release before accepting one.
  always_comb begin
    state_nx = state;
    case (state)
      NOROM:   state_nx = (dl_rise && rst_sync[1]) ? LOAD : NOROM;
      LOAD:    state_nx = dl_fall ? CHECK : LOAD;
      CHECK:   state_nx = valid ? HOLD : NOROM;
      HOLD:    state_nx = dl_rise ? LOAD : (hold_cnt == 16'(HOLD_CYCLES - 1) && !cause) ? RUN : HOLD;
      RUN:     state_nx = dl_rise ? LOAD : cause ? HOLD : RUN;
      default: state_nx = NOROM;
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
      state    <= NOROM;
      dl_q     <= 1'b0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      state    <= state_nx;
      dl_q     <= rom_dl;
    end
  end
  // core_reset is driven from the next state so it drops on the first RUN cycle.
  // A write landing in the cycle LOAD is entered counts as the first byte.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt   <= 16'd0;
      byte_cnt   <= 15'd0;
      nz         <= 1'b0;
      rom_ok     <= 1'b0;
      load_err   <= 1'b0;
      core_reset <= 1'b1;
      dn_wr      <= 1'b0;
      dn_addr    <= 14'd0;
      dn_data    <= 8'd0;
      led_n      <= 1'b1;
    end else begin
      hold_cnt <= (state == HOLD && !cause) ? hold_cnt + 16'd1 : 16'd0;
      if (load_entry) begin
        byte_cnt <= {14'd0, acc};
        nz       <= acc && |ioctl_dout;
      end else if (state == LOAD && acc) begin
        byte_cnt <= (byte_cnt == 15'(ROM_SIZE)) ? byte_cnt : byte_cnt + 15'd1;
        nz       <= nz || |ioctl_dout;
      end
      rom_ok     <= load_entry ? 1'b0 : (state == CHECK) ? valid : rom_ok;
      load_err   <= (state == CHECK) ? !valid : load_err;
      core_reset <= state_nx != RUN;
      dn_wr      <= acc;
      dn_addr    <= ioctl_addr[13:0];
      dn_data    <= ioctl_dout;
      led_n      <= !ioctl_downl;
    end
  end
endmodule

// File: tb/tb_game_reset_sequencer.sv
// tb_game_reset_sequencer: randomized self-checking bench for game_reset_sequencer.
module tb_game_reset_sequencer;
  localparam int RS = 16384;
  localparam int HC = 1024;
  logic        clk_sys = 1'b0, reset_n = 1'b1;
  logic        ioctl_downl = 1'b0, ioctl_wr = 1'b0, status_rst = 1'b0, button_rst = 1'b0;
  logic [7:0]  ioctl_index = 8'h00, ioctl_dout = 8'h00;
  logic [24:0] ioctl_addr = 25'd0;
  logic        core_reset, dn_wr, rom_ok, load_err, led_n;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data;
  int          n_cmp = 0, n_bad = 0, cr_hi = 0;
  game_reset_sequencer #(.ROM_INDEX(8'h00), .ROM_SIZE(RS), .HOLD_CYCLES(HC)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .status_rst(status_rst),
    .button_rst(button_rst), .core_reset(core_reset), .dn_wr(dn_wr), .dn_addr(dn_addr),
    .dn_data(dn_data), .rom_ok(rom_ok), .load_err(load_err), .led_n(led_n)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_rst();
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_dn_wr", 32'(dn_wr), 32'd0);
    chk("rst_dn_addr", 32'(dn_addr), 32'd0);
    chk("rst_dn_data", 32'(dn_data), 32'd0);
    chk("rst_rom_ok", 32'(rom_ok), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_led_n", 32'(led_n), 32'd1);
  endtask
  task automatic tick();
    logic on, e_wr, e_led;
    logic [13:0] e_addr;
    logic [7:0] e_data;
    on     = reset_n;
    e_wr   = on && ioctl_wr && ioctl_downl && ioctl_index == 8'h00 && ioctl_addr < 25'(RS);
    e_addr = on ? ioctl_addr[13:0] : 14'd0;
    e_data = on ? ioctl_dout : 8'd0;
    e_led  = on ? !ioctl_downl : 1'b1;
    @(posedge clk_sys);
    #1;
    chk("dn_wr", 32'(dn_wr), 32'(e_wr));
    chk("dn_addr", 32'(dn_addr), 32'(e_addr));
    chk("dn_data", 32'(dn_data), 32'(e_data));
    chk("led_n", 32'(led_n), 32'(e_led));
    if (core_reset) cr_hi++;
  endtask
  // kind: 0 = addr[7:0]+1, 1 = all zero, 2 = random bytes; oor = out-of-range writes of 8'hff up front
  task automatic load(input int n, input int kind, input logic [7:0] idx, input int oor,
                      input int gap_max, input int abort_at, output bit good);
    int acc;
    bit nz;
    acc = 0;
    nz  = 1'b0;
    good = 1'b0;
    ioctl_index = idx;
    ioctl_downl = 1'b1;
    tick();
    status_rst = 1'b0;
    button_rst = 1'b0;
    if (idx == 8'h00) begin
      chk("entry_core_reset", 32'(core_reset), 32'd1);
      chk("entry_rom_ok", 32'(rom_ok), 32'd0);
    end
    for (int i = 0; i < oor; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(RS + $urandom_range(0, 1000000));
      ioctl_dout = 8'hff;
      tick();
    end
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk_rst();
        ioctl_wr    = 1'b0;
        ioctl_downl = 1'b0;
        repeat (3) tick();
        chk_rst();
        reset_n = 1'b1;
        repeat (4) tick();
        return;
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = (kind == 0) ? 8'(i + 1) : (kind == 1) ? 8'h00 : 8'($urandom);
      acc++;
      nz |= (ioctl_dout != 8'h00);
      tick();
      ioctl_wr = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
    ioctl_wr    = 1'b0;
    ioctl_downl = 1'b0;
    tick();
    good = (acc >= RS) && nz;
  endtask
  task automatic judge(input bit good, input int watch);
    int n;
    tick();
    chk("rom_ok", 32'(rom_ok), 32'(good));
    chk("load_err", 32'(load_err), 32'(!good));
    if (good) begin
      n = 1;
      while (core_reset && n < 3 * HC) begin
        tick();
        n++;
      end
      chk("hold_len", n, HC + 1);
    end else begin
      cr_hi = 0;
      repeat (watch) tick();
      chk("stay_reset", cr_hi, watch);
    end
  endtask
  task automatic pulse(input bit use_status, input int len);
    int n;
    if (use_status) status_rst = 1'b1;
    else button_rst = 1'b1;
    tick();
    n = 1;
    chk("cause_core_reset", 32'(core_reset), 32'd1);
    repeat (len - 1) begin
      tick();
      n++;
    end
    status_rst = 1'b0;
    button_rst = 1'b0;
    while (core_reset && n < len + 3 * HC) begin
      tick();
      n++;
    end
    chk("cause_len", n, len + HC);
  endtask
  initial begin
    bit g;
    #3 reset_n = 1'b0;
    #1 chk_rst();
    repeat (3) tick();
    chk_rst();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("idle_core_reset", 32'(core_reset), 32'd1);
    load(100, 0, 8'h00, 0, 0, -1, g);
    judge(g, 1100);
    load(0, 0, 8'h00, 0, 0, -1, g);
    judge(g, 50);
    repeat (3) begin
      load($urandom_range(1, 200), 2, 8'h00, $urandom_range(0, 3), 2, -1, g);
      judge(g, 50);
    end
    load(RS, 0, 8'h00, 0, 0, -1, g);
    judge(g, 0);
    pulse(1'b0, 10);
    pulse(1'b1, $urandom_range(1, 20));
    cr_hi = 0;
    load(50, 2, 8'h01, 0, 0, -1, g);
    repeat (5) tick();
    chk("foreign_idx_core_reset", cr_hi, 0);
    chk("foreign_idx_rom_ok", 32'(rom_ok), 32'd1);
    button_rst = 1'b1;
    load(RS, 1, 8'h00, 3, 0, -1, g);
    judge(g, 50);
    load(RS, 0, 8'h00, 0, 0, 8000, g);
    load(RS, 0, 8'h00, 0, 0, -1, g);
    judge(g, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
